uart_arbiter: RTL

//  Shares the single miniuart2 I/O port between NREQ j1 cores in cpu_top.

---
 rtl/uart_arbiter_pkg.sv | 15 +
 rtl/uart_arbiter_rr_pick.sv | 31 +++
 rtl/uart_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared types for the miniuart2 port arbiter: FSM state encoding and owner index width.
package uart_arbiter_pkg;

    localparam int OWNER_W = 3;

    typedef logic [OWNER_W-1:0] owner_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester strictly after i_last, wrapping.
module uart_arbiter_rr_pick
    import uart_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  owner_t          i_last,
    output owner_t          o_grant,
    output logic            o_any
);

    always_comb begin
        int v_dist;
        int v_best;
        o_grant = '0;
        o_any   = 1'b0;
        v_dist  = 0;
        v_best  = NREQ;
        // Distance 0 is the core right after i_last; the smallest distance wins.
        for (int i = 0; i < NREQ; i++) begin
            v_dist = (i + 2 * NREQ - 1 - int'(i_last)) % NREQ;
            if (i_req[i] && (v_dist < v_best)) begin
                v_best  = v_dist;
                o_grant = owner_t'(i);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one miniuart2 port between NREQ cores, with optional lock.
// Define UART_ARB_TIMEOUT_EN to force a locked but idle owner off after TIMEOUT cycles.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ-1:0]   i_req_wr,
    input  logic [NREQ-1:0]   i_lock,
    input  logic [NREQ*2-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_din,
    output logic [NREQ-1:0]   o_ack,
    output logic [DW-1:0]     o_rdata,
    output logic [DW-1:0]     o_status,
    output logic [OWNER_W-1:0] o_owner,
    output logic              o_busy,
    output logic              o_uart_rd,
    output logic              o_uart_wr,
    output logic [1:0]        o_uart_addr,
    output logic [DW-1:0]     o_uart_din,
    input  logic [DW-1:0]     i_uart_dout,
    input  logic [DW-1:0]     i_uart_dout1
);

    arb_state_e      r_state;
    owner_t          r_owner;
    owner_t          r_rr_last;
    logic [NREQ-1:0] r_ack;
    logic [DW-1:0]   r_rdata;
    logic            r_rd;
    logic            r_wr;
    logic [1:0]      r_addr;
    logic [DW-1:0]   r_din;

    owner_t          w_grant;
    owner_t          w_sel;
    logic            w_any;
    logic            w_start;
    logic            w_sel_wr;
    logic [1:0]      w_sel_addr;
    logic [DW-1:0]   w_sel_din;
    logic            w_own_lock;
    logic            w_own_req;
    logic [NREQ-1:0] w_owner_hot;

    uart_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .i_req   (i_req),
        .i_last  (r_rr_last),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    // In HOLD only the current owner may start a new access.
    assign w_sel   = (r_state == ST_HOLD) ? r_owner : w_grant;
    assign w_start = ((r_state == ST_IDLE) && w_any) ||
                     ((r_state == ST_HOLD) && w_own_lock && w_own_req);

    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_din   = '0;
        w_own_lock  = 1'b0;
        w_own_req   = 1'b0;
        w_owner_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == owner_t'(i)) begin
                w_sel_wr   = i_req_wr[i];
                w_sel_addr = i_req_addr[i*2 +: 2];
                w_sel_din  = i_req_din[i*DW +: DW];
            end
            if (r_owner == owner_t'(i)) begin
                w_own_lock     = i_lock[i];
                w_own_req      = i_req[i];
                w_owner_hot[i] = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TMO_W-1:0] r_tmo;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_rr_last <= owner_t'(NREQ - 1);
            r_ack     <= '0;
            r_rdata   <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            // NOTE: pulse outputs default low every cycle with <=; only the states below raise them.
            r_ack <= '0;
            r_rd  <= 1'b0;
            r_wr  <= 1'b0;
            if (w_start) begin
                r_owner <= w_sel;
                r_addr  <= w_sel_addr;
                r_din   <= w_sel_din;
                r_rd    <= ~w_sel_wr;
                r_wr    <= w_sel_wr;
                r_state <= ST_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                r_tmo   <= '0;
`endif
            end else begin
                case (r_state)
                    // rdata is loaded with ack so both are visible in the same cycle.
                    ST_ISSUE: begin
                        r_ack   <= w_owner_hot;
                        r_rdata <= i_uart_dout;
                        r_state <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        r_rr_last <= r_owner;
                        r_state   <= w_own_lock ? ST_HOLD : ST_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                        r_tmo     <= '0;
`endif
                    end
                    ST_HOLD: begin
                        if (!w_own_lock) begin
                            r_state <= ST_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_status    = i_uart_dout1;
    assign o_owner     = r_owner;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_uart_rd   = r_rd;
    assign o_uart_wr   = r_wr;
    assign o_uart_addr = r_addr;
    assign o_uart_din  = r_din;

endmodule
